// File: rtl/mux_out_drain_ctrl.sv
// ---------------------------------------------------------------------------
// mux_out_drain_ctrl
//
// Drains all 16 memory banks to a streaming output port once a transform
// has completed. For every bank address it issues one common bank read, then
// steps the 16:1 output mux select through 0..15, so the stream carries the
// words in the order k = addr*16 + bank. The next address is prefetched in
// the same cycle that the last bank word of the current address is accepted,
// so consecutive addresses stream back-to-back with no bubble cycles.
//
// Handshake: a word transfers ("fires") on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the controller holds
// sel_out and out_last, and it does not pulse rd_en, so the bank output Q and
// the mux output stay stable until the word is accepted.
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset (aborts a drain, no done)
//   start          in   pulse to begin a drain; only honoured in IDLE
//   cfg_last_addr  in   last bank address to drain, latched with start
//   rd_en          out  common bank read enable (Q valid next cycle)
//   rd_addr        out  bank read address, meaningful when rd_en=1
//   sel_out        out  select for the 16:1 output mux
//   out_valid      out  mux output holds a valid word
//   out_ready      in   downstream accepts the current word
//   out_last       out  current word is the final word of the drain
//   busy           out  drain in progress (FETCH, STREAM, DONE)
//   done           out  one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module mux_out_drain_ctrl #(
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_last_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [SEL_W-1:0]  sel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] SEL_MAX = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt;
  logic [ADDR_W-1:0] last_q, last_nxt;

  logic fire;
  logic at_last_addr;
  logic at_last_sel;

  assign fire         = out_valid & out_ready;
  assign at_last_addr = (addr_q == last_q);
  assign at_last_sel  = (sel_q == SEL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      sel_q  <= '0;
      last_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      sel_q  <= sel_nxt;
      last_q <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    sel_nxt   = sel_q;
    last_nxt  = last_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    sel_out   = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          last_nxt  = cfg_last_addr;
          addr_nxt  = '0;
          sel_nxt   = '0;
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        rd_en     = 1'b1;
        rd_addr   = addr_q;
        busy      = 1'b1;
        state_nxt = S_STREAM;
      end

      S_STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        sel_out   = sel_q;
        rd_addr   = addr_q;
        out_last  = at_last_addr && at_last_sel;
        // out_valid is 1 here, so fire reduces to out_ready; rd_en is only
        // raised on the accepting edge of bank 15, keeping Q stable under
        // back-pressure.
        if (fire) begin
          if (!at_last_sel) begin
            sel_nxt = sel_q + 1'b1;
          end else if (!at_last_addr) begin
            // Prefetch: the next address is read on the same edge the last
            // bank word is accepted, so its Q arrives for sel 0 next cycle.
            rd_en    = 1'b1;
            rd_addr  = addr_q + 1'b1;
            addr_nxt = addr_q + 1'b1;
            sel_nxt  = '0;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_out_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_out_drain_ctrl
//
// Bench for mux_out_drain_ctrl. A behavioural bank model (random contents,
// one registered read address shared by all banks) supplies Q_out through the
// mux select. Each accepted start pushes the full expected word stream
// ({last flag, data}) into exp_q; an independent monitor pops and compares on
// every fire and also checks read/prefetch rules, stall stability and done.
// ---------------------------------------------------------------------------
module tb_mux_out_drain_ctrl;
  localparam int ADDR_W = 4;
  localparam int SEL_W  = 4;
  localparam int W      = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] cfg_last_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [SEL_W-1:0]  sel_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  mux_out_drain_ctrl #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_last_addr(cfg_last_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .sel_out(sel_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // Bank model: 16 banks x 16 addresses, synchronous read, Q holds.
  logic [15:0]       mem [16][16];
  logic [ADDR_W-1:0] q_addr = '0;
  logic [15:0]       q_out;
  assign q_out = mem[q_addr][sel_out];
  always @(posedge clk) if (rd_en) q_addr <= rd_addr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and statistics.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fires, rd_cnt, last_cnt, done_cnt;
  int first_valid_cyc, last_fire_cyc, done_cyc;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: test-driven

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_stats();
    fires = 0; rd_cnt = 0; last_cnt = 0; done_cnt = 0;
    first_valid_cyc = -1; last_fire_cyc = -1; done_cyc = -1;
  endtask

  // Ready driver.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor.
  logic         hold_pend = 1'b0;
  logic [31:0]  hold_val;
  logic [W-1:0] exp_word;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        if (out_valid) begin
          check("prefetch_sel", 32'(sel_out), 32'd15);
          check("prefetch_ready", 32'(out_ready), 32'd1);
          check("prefetch_addr", 32'(rd_addr), 32'(q_addr) + 32'd1);
        end else begin
          check("fetch_addr", 32'(rd_addr), 32'd0);
        end
      end
      if (hold_pend) check("stall_hold", {11'd0, sel_out, out_last, q_out}, hold_val);
      hold_pend = out_valid && !out_ready;
      hold_val  = {11'd0, sel_out, out_last, q_out};
      if (out_valid && out_ready) begin
        fires++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        last_fire_cyc = cyc;
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_word: got %0h expected no word (cycle %0d)", q_out, cyc);
        end else begin
          exp_word = exp_q.pop_front();
          check("word", 32'({out_last, q_out}), 32'(exp_word));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_drained", exp_q.size(), 32'd0);
      end
    end
  end

  // Issue a start in IDLE and queue the expected stream.
  task automatic run_drain(input int last, output int c0);
    @(posedge clk); #1;
    clear_stats();
    cfg_last_addr = ADDR_W'(last);
    start = 1'b1;
    c0 = cyc;
    for (int a = 0; a <= last; a++)
      for (int b = 0; b < 16; b++)
        exp_q.push_back({(a == last) && (b == 15), mem[a][b]});
    @(posedge clk); #1;
    start = 1'b0;
    cfg_last_addr = ADDR_W'($urandom_range(0, 15));
  endtask

  task automatic wait_done_flag(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(posedge clk); #1; n++; end
    if (!done) begin
      checks++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic wait_done(input int budget);
    wait_done_flag(budget);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, n;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mem[a][b] = 16'($urandom);
    clear_stats();
    rst = 1'b1; start = 1'b0; cfg_last_addr = '0; out_ready = 1'b0; ready_mode = 2;

    // 1: reset, then single-address drain timing.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {rd_en, rd_addr, sel_out, out_valid, out_last, busy, done}, 32'd0);
    ready_mode = 0;
    run_drain(0, c0);
    wait_done(100);
    check("t1_first_valid", first_valid_cyc - c0, 32'd2);
    check("t1_last_fire", last_fire_cyc - c0, 32'd17);
    check("t1_done", done_cyc - c0, 32'd18);
    check("t1_words", fires, 32'd16);
    check("t1_reads", rd_cnt, 32'd1);
    check("t1_last_cnt", last_cnt, 32'd1);
    check("t1_done_cnt", done_cnt, 32'd1);

    // 2: three addresses, no gaps.
    run_drain(2, c0);
    wait_done(200);
    check("t2_words", fires, 32'd48);
    check("t2_no_gap", last_fire_cyc - first_valid_cyc, 32'd47);
    check("t2_reads", rd_cnt, 32'd3);
    check("t2_done", done_cyc - c0, 32'd50);

    // 3: back-pressure on the sel=15 word of addr 0.
    ready_mode = 2; out_ready = 1'b1;
    run_drain(1, c0);
    n = 0;
    while (!(out_valid && sel_out == 4'd15 && q_addr == 4'd0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("t3_reached_sel15", 32'(out_valid && sel_out == 4'd15), 32'd1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(200);
    check("t3_words", fires, 32'd32);
    check("t3_reads", rd_cnt, 32'd2);
    check("t3_done", done_cyc - c0, 32'd37);

    // 4: random ready, full 256-word drain.
    ready_mode = 1;
    run_drain(15, c0);
    wait_done(3000);
    check("t4_words", fires, 32'd256);
    check("t4_reads", rd_cnt, 32'd16);
    check("t4_last_cnt", last_cnt, 32'd1);
    check("t4_done_cnt", done_cnt, 32'd1);

    // 5: start while busy and in the DONE cycle is ignored.
    ready_mode = 0;
    run_drain(1, c0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; cfg_last_addr = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done_flag(200);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_words", fires, 32'd32);
    check("t5_done_cnt", done_cnt, 32'd1);
    check("t5_idle", 32'(busy), 32'd0);
    ready_mode = 1;
    run_drain(2, c0);
    wait_done(500);
    check("t5_rerun_words", fires, 32'd48);

    // 6: reset mid-stream aborts without done.
    ready_mode = 0;
    run_drain(3, c0);
    n = 0;
    while (!(out_valid && sel_out == 4'd7 && q_addr == 4'd1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("t6_reached_a1s7", 32'(out_valid && sel_out == 4'd7 && q_addr == 4'd1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    @(negedge clk);
    check("t6_abort_outputs", {rd_en, rd_addr, sel_out, out_valid, out_last, busy, done}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, 32'd0);
    run_drain(1, c0);
    wait_done(100);
    check("t6_rerun_words", fires, 32'd32);
    check("t6_rerun_first", first_valid_cyc - c0, 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
